// File: rtl/floo_route_comp_pipe.sv
// Purpose : per-channel route computation (destination ID + source route) for the NoC injection path.
// Latency : 1 cycle from input handshake to registered result.
// Backpressure: per channel, in_ready_o = !out_valid_o || out_ready_i; a held result stays stable until taken.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   in_valid_i/in_ready_o            per-channel request handshake
//   in_addr_i, in_id_i               request address / source ID (packed, channel c at [c*W +: W])
//   out_valid_o/out_ready_i          per-channel result handshake
//   out_id_o, out_route_o, out_err_o destination ID, source route, decode error of the held beat
//   rule_start_i/rule_end_i/rule_id_i address rules [start, end) -> id, higher index wins
//   en_default_i, default_id_i       fallback ID on rule miss (miss is an error unless enabled)
//   cfg_we_i/cfg_idx_i/cfg_wdata_i   route-table write port
//   err_clr_i, err_cnt_o             shared saturating decode-error counter
//
// Optional feature macro: FLOO_ROUTE_COMP_CFG_LOCK_EN
//   adds cfg_lock_i / cfg_locked_o; once locked (sticky until reset) table writes are ignored.

module floo_route_comp_pipe #(
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned AddrWidth    = 48,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned RouteWidth   = 16,
  parameter int unsigned NumRoutes    = 16,
  parameter int unsigned NumRules     = 8,
  parameter int unsigned IdMode       = 0,
  parameter int unsigned IdAddrOffset = 32,
  localparam int unsigned IdxWidth    = (NumRoutes > 1) ? $clog2(NumRoutes) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumChannels-1:0]          in_valid_i,
  output logic [NumChannels-1:0]          in_ready_o,
  input  logic [NumChannels*AddrWidth-1:0] in_addr_i,
  input  logic [NumChannels*IdWidth-1:0]  in_id_i,
  output logic [NumChannels-1:0]          out_valid_o,
  input  logic [NumChannels-1:0]          out_ready_i,
  output logic [NumChannels*IdWidth-1:0]  out_id_o,
  output logic [NumChannels*RouteWidth-1:0] out_route_o,
  output logic [NumChannels-1:0]          out_err_o,
  input  logic [NumRules*AddrWidth-1:0]   rule_start_i,
  input  logic [NumRules*AddrWidth-1:0]   rule_end_i,
  input  logic [NumRules*IdWidth-1:0]     rule_id_i,
  input  logic                            en_default_i,
  input  logic [IdWidth-1:0]              default_id_i,
  input  logic                            cfg_we_i,
  input  logic [IdxWidth-1:0]             cfg_idx_i,
  input  logic [RouteWidth-1:0]           cfg_wdata_i,
  input  logic                            err_clr_i,
  output logic [7:0]                      err_cnt_o
`ifdef FLOO_ROUTE_COMP_CFG_LOCK_EN
  ,
  input  logic                            cfg_lock_i,
  output logic                            cfg_locked_o
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [RouteWidth-1:0] table_q [NumRoutes];
  logic [RouteWidth-1:0] table_d [NumRoutes];

  logic [NumChannels-1:0]                 valid_q, valid_d;
  logic [NumChannels-1:0][IdWidth-1:0]    id_q, id_d;
  logic [NumChannels-1:0][RouteWidth-1:0] route_q, route_d;
  logic [NumChannels-1:0]                 err_q, err_d;
  logic [7:0]                             err_cnt_q, err_cnt_d;

  // Combinational decode results, one per channel, before the output register.
  logic [NumChannels-1:0][IdWidth-1:0]    dec_id;
  logic [NumChannels-1:0][RouteWidth-1:0] dec_route;
  logic [NumChannels-1:0]                 dec_err;

  logic [NumChannels-1:0] capture;
  logic                   tbl_we;

`ifdef FLOO_ROUTE_COMP_CFG_LOCK_EN
  logic cfg_locked_q, cfg_locked_d;

  // Sticky lock; the write-enable gate uses the registered value so a write
  // issued together with the lock request still lands.
  always_comb begin
    cfg_locked_d = cfg_locked_q | cfg_lock_i;
  end

  assign cfg_locked_o = cfg_locked_q;
  assign tbl_we       = cfg_we_i & ~cfg_locked_q;
`else
  assign tbl_we       = cfg_we_i;
`endif

  // ---------------------------------------------------------------------------
  // Route-table write. Lookups below read table_q, so a capture in the same
  // cycle as a write sees the old entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    table_d = table_q;
    if (tbl_we && (32'(cfg_idx_i) < NumRoutes)) begin
      table_d[cfg_idx_i] = cfg_wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // ID computation and route lookup. All three ID sources are always built so
  // the mode select is a plain mux; unused sources are optimised away.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [AddrWidth-1:0] addr;
    logic [IdWidth-1:0]   id_addr;
    logic [IdWidth-1:0]   id_rule;
    logic [IdWidth-1:0]   id_in;
    logic [IdWidth-1:0]   id_sel;
    logic                 rule_hit;
    logic                 mode_err;

    dec_id    = '0;
    dec_route = '0;
    dec_err   = '0;
    addr      = '0;
    id_addr   = '0;
    id_rule   = '0;
    id_in     = '0;
    id_sel    = '0;
    rule_hit  = 1'b0;
    mode_err  = 1'b0;

    for (int c = 0; c < NumChannels; c++) begin
      addr    = in_addr_i[c*AddrWidth +: AddrWidth];
      id_addr = addr[IdAddrOffset +: IdWidth];
      id_in   = in_id_i[c*IdWidth +: IdWidth];

      // Ascending scan: a later (higher-index) match overrides earlier ones.
      rule_hit = 1'b0;
      id_rule  = default_id_i;
      for (int r = 0; r < NumRules; r++) begin
        if ((addr >= rule_start_i[r*AddrWidth +: AddrWidth]) &&
            (addr <  rule_end_i[r*AddrWidth +: AddrWidth])) begin
          rule_hit = 1'b1;
          id_rule  = rule_id_i[r*IdWidth +: IdWidth];
        end
      end

      if (IdMode == 0) begin
        id_sel   = id_addr;
        mode_err = 1'b0;
      end else if (IdMode == 1) begin
        id_sel   = id_rule;
        mode_err = ~rule_hit & ~en_default_i;
      end else begin
        id_sel   = id_in;
        mode_err = 1'b0;
      end

      dec_id[c] = id_sel;
      if (32'(id_sel) < NumRoutes) begin
        dec_route[c] = table_q[id_sel[IdxWidth-1:0]];
        dec_err[c]   = mode_err;
      end else begin
        // IDs beyond the table have no route; forward the beat flagged.
        dec_route[c] = '0;
        dec_err[c]   = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One-stage valid/ready register per channel.
  // ---------------------------------------------------------------------------
  assign in_ready_o = ~valid_q | out_ready_i;
  assign capture    = in_valid_i & in_ready_o;

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    route_d = route_q;
    err_d   = err_q;
    for (int c = 0; c < NumChannels; c++) begin
      if (capture[c]) begin
        valid_d[c] = 1'b1;
        id_d[c]    = dec_id[c];
        route_d[c] = dec_route[c];
        err_d[c]   = dec_err[c];
      end else if (out_ready_i[c]) begin
        valid_d[c] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared error counter: clear takes effect before this cycle's increments.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [15:0] sum;
    sum = err_clr_i ? 16'd0 : {8'd0, err_cnt_q};
    for (int c = 0; c < NumChannels; c++) begin
      if (capture[c] && dec_err[c]) begin
        sum = sum + 16'd1;
      end
    end
    err_cnt_d = (sum > 16'd255) ? 8'hFF : sum[7:0];
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      id_q      <= '0;
      route_q   <= '0;
      err_q     <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < NumRoutes; i++) begin
        table_q[i] <= '0;
      end
`ifdef FLOO_ROUTE_COMP_CFG_LOCK_EN
      cfg_locked_q <= 1'b0;
`endif
    end else begin
      valid_q   <= valid_d;
      id_q      <= id_d;
      route_q   <= route_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      table_q   <= table_d;
`ifdef FLOO_ROUTE_COMP_CFG_LOCK_EN
      cfg_locked_q <= cfg_locked_d;
`endif
    end
  end

  assign out_valid_o = valid_q;
  assign out_id_o    = id_q;
  assign out_route_o = route_q;
  assign out_err_o   = err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_floo_route_comp_pipe.sv
module tb_floo_route_comp_pipe;

  localparam int AW = 48;
  localparam int IW = 4;
  localparam int RW = 16;
  localparam int NR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  v0, v1, ir0, ir1, ov0, ov1, rdy0, rdy1, oe0, oe1;
  logic [2*AW-1:0] a0, a1;
  logic [2*IW-1:0] iid;
  logic [2*IW-1:0] oid0, oid1;
  logic [2*RW-1:0] or0, or1;
  logic [NR*AW-1:0] rs, re;
  logic [NR*IW-1:0] rid;
  logic        en_def;
  logic [IW-1:0] def_id;
  logic        we;
  logic [3:0]  widx;
  logic [RW-1:0] wdat;
  logic        clr;
  logic [7:0]  ec0, ec1;
`ifdef FLOO_ROUTE_COMP_CFG_LOCK_EN
  logic        lock, locked0, locked1;
`endif

  int tests = 0;
  int fails = 0;

  // IdMode 0, table shorter than the ID space so out-of-range IDs are reachable.
  floo_route_comp_pipe #(.IdMode(0), .NumRoutes(12)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(v0), .in_ready_o(ir0), .in_addr_i(a0), .in_id_i(iid),
    .out_valid_o(ov0), .out_ready_i(rdy0), .out_id_o(oid0), .out_route_o(or0), .out_err_o(oe0),
    .rule_start_i(rs), .rule_end_i(re), .rule_id_i(rid),
    .en_default_i(en_def), .default_id_i(def_id),
    .cfg_we_i(we), .cfg_idx_i(widx), .cfg_wdata_i(wdat),
    .err_clr_i(clr), .err_cnt_o(ec0)
`ifdef FLOO_ROUTE_COMP_CFG_LOCK_EN
    , .cfg_lock_i(lock), .cfg_locked_o(locked0)
`endif
  );

  // IdMode 1, address-rule decode.
  floo_route_comp_pipe #(.IdMode(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(v1), .in_ready_o(ir1), .in_addr_i(a1), .in_id_i(iid),
    .out_valid_o(ov1), .out_ready_i(rdy1), .out_id_o(oid1), .out_route_o(or1), .out_err_o(oe1),
    .rule_start_i(rs), .rule_end_i(re), .rule_id_i(rid),
    .en_default_i(en_def), .default_id_i(def_id),
    .cfg_we_i(we), .cfg_idx_i(widx), .cfg_wdata_i(wdat),
    .err_clr_i(clr), .err_cnt_o(ec1)
`ifdef FLOO_ROUTE_COMP_CFG_LOCK_EN
    , .cfg_lock_i(lock), .cfg_locked_o(locked1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IdMode 0 address carrying the ID at bit 32.
  function automatic logic [AW-1:0] id_addr(input logic [3:0] id);
    logic [AW-1:0] a;
    a = '0;
    a[35:32] = id;
    return a;
  endfunction

  initial begin
    logic [1:0] seen;

    rst = 1'b1; v0 = '0; v1 = '0; a0 = '0; a1 = '0; iid = '0;
    rdy0 = 2'b11; rdy1 = 2'b11; en_def = 1'b0; def_id = 4'd7;
    we = 1'b0; widx = '0; wdat = '0; clr = 1'b0;
`ifdef FLOO_ROUTE_COMP_CFG_LOCK_EN
    lock = 1'b0;
`endif
    // Rules: [0x0,0x1000)->1, [0x800,0x2000)->3; others empty ranges.
    rs = '0; re = '0; rid = '0;
    re[0*AW +: AW]  = 48'h1000;
    rid[0*IW +: IW] = 4'd1;
    rs[1*AW +: AW]  = 48'h800;
    re[1*AW +: AW]  = 48'h2000;
    rid[1*IW +: IW] = 4'd3;

    // ---------------- reset ----------------
    step(); step();
    rst = 1'b0;
    chk("rst_valid0", ov0, 2'b00);
    chk("rst_valid1", ov1, 2'b00);
    chk("rst_id0", oid0, 8'h00);
    chk("rst_route0", or0, 32'h0);
    chk("rst_err0", oe0, 2'b00);
    chk("rst_cnt0", ec0, 8'd0);
    chk("rst_cnt1", ec1, 8'd0);
    chk("rst_ready0", ir0, 2'b11);
    chk("rst_ready1", ir1, 2'b11);
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | ov0 | ov1;
    end
    chk("idle_no_valid", seen, 2'b00);

    // ---------------- table writes ----------------
    we = 1'b1; widx = 4'd5; wdat = 16'h00A5;
    step();
    widx = 4'd3; wdat = 16'h0333;
    step();
    we = 1'b0;

    // ---------------- IdMode 0 ----------------
    a0[AW-1:0] = 48'h0000_0005_0000_1000;
    v0 = 2'b01;
    step();
    v0 = 2'b00;
    chk("m0_valid", ov0, 2'b01);
    chk("m0_id", oid0[3:0], 4'd5);
    chk("m0_route", or0[15:0], 16'h00A5);
    chk("m0_err", oe0[0], 1'b0);
    step();
    chk("m0_drain", ov0, 2'b00);

    // Read-before-write on table[6].
    a0[AW-1:0] = id_addr(4'd6);
    v0 = 2'b01; we = 1'b1; widx = 4'd6; wdat = 16'h0066;
    step();
    we = 1'b0;
    chk("rbw_old", or0[15:0], 16'h0000);
    step();
    v0 = 2'b00;
    chk("rbw_new", or0[15:0], 16'h0066);

    // ID beyond a 12-entry table on channel 1.
    a0[2*AW-1:AW] = id_addr(4'd13);
    v0 = 2'b10;
    step();
    v0 = 2'b00;
    chk("oor_id", oid0[7:4], 4'd13);
    chk("oor_route", or0[31:16], 16'h0000);
    chk("oor_err", oe0[1], 1'b1);
    chk("oor_cnt", ec0, 8'd1);

    // ---------------- IdMode 1 ----------------
    a1[AW-1:0] = 48'h900; a1[2*AW-1:AW] = 48'h100;
    v1 = 2'b11;
    step();
    chk("m1_ids", oid1, 8'h13);
    chk("m1_routes", or1, {16'h0000, 16'h0333});
    chk("m1_err", oe1, 2'b00);
    chk("m1_cnt", ec1, 8'd0);

    // Range edges: 0x7FF only in rule 0; 0x1000 past rule 0 end, inside rule 1.
    a1[AW-1:0] = 48'h7FF; a1[2*AW-1:AW] = 48'h1000;
    step();
    chk("m1_edge_ids", oid1, 8'h31);
    chk("m1_edge_routes", or1, {16'h0333, 16'h0000});

    // Miss without default.
    a1[AW-1:0] = 48'h3000;
    v1 = 2'b01;
    step();
    chk("miss_id", oid1[3:0], 4'd7);
    chk("miss_err", oe1[0], 1'b1);
    chk("miss_cnt", ec1, 8'd1);

    // Miss with default enabled (0x2000 is past rule 1 end).
    en_def = 1'b1;
    a1[AW-1:0] = 48'h2000;
    step();
    v1 = 2'b00; en_def = 1'b0;
    chk("def_id", oid1[3:0], 4'd7);
    chk("def_err", oe1[0], 1'b0);
    chk("def_cnt", ec1, 8'd1);

    // ---------------- backpressure on u_dut0 channel 0 ----------------
    rdy0 = 2'b10;
    a0[AW-1:0] = id_addr(4'd5);
    v0 = 2'b01;
    step();
    a0[AW-1:0] = id_addr(4'd3);
    a0[2*AW-1:AW] = id_addr(4'd6);
    v0 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready_low", ir0[0], 1'b0);
      step();
      chk("bp_hold_valid", ov0[0], 1'b1);
      chk("bp_hold_id", oid0[3:0], 4'd5);
      chk("bp_hold_route", or0[15:0], 16'h00A5);
      if (i == 0) begin
        chk("bp_ch1_id", oid0[7:4], 4'd6);
        chk("bp_ch1_route", or0[31:16], 16'h0066);
        v0 = 2'b01;
      end
    end
    rdy0 = 2'b11;
    #1;
    chk("bp_release_ready", ir0[0], 1'b1);
    step();
    v0 = 2'b00;
    chk("bp_next_id", oid0[3:0], 4'd3);
    chk("bp_next_route", or0[15:0], 16'h0333);

    // ---------------- saturation and clear on u_dut1 ----------------
    a1[AW-1:0] = 48'h3000; a1[2*AW-1:AW] = 48'h3000;
    v1 = 2'b11;
    for (int i = 0; i < 130; i++) begin
      step();
    end
    chk("sat_cnt", ec1, 8'd255);
    clr = 1'b1;
    step();
    chk("clr_plus_two", ec1, 8'd2);
    v1 = 2'b00;
    step();
    clr = 1'b0;
    chk("clr_only", ec1, 8'd0);
    v1 = 2'b10;
    step();
    v1 = 2'b00;
    chk("cnt_after_clr", ec1, 8'd1);

    // ---------------- reset mid-transfer ----------------
    rdy0 = 2'b00;
    a0[AW-1:0] = id_addr(4'd5);
    v0 = 2'b01;
    step();
    v0 = 2'b00;
    chk("mid_held", ov0, 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", ov0, 2'b00);
    chk("mid_rst_id", oid0, 8'h00);
    chk("mid_rst_ready", ir0, 2'b11);
    rdy0 = 2'b11;
    v0 = 2'b01;
    step();
    v0 = 2'b00;
    chk("tbl_cleared_id", oid0[3:0], 4'd5);
    chk("tbl_cleared_route", or0[15:0], 16'h0000);

`ifdef FLOO_ROUTE_COMP_CFG_LOCK_EN
    // ---------------- configuration lock ----------------
    chk("lock_rst", locked0, 1'b0);
    we = 1'b1; widx = 4'd2; wdat = 16'h0011;
    step();
    we = 1'b0; lock = 1'b1;
    step();
    lock = 1'b0;
    we = 1'b1; wdat = 16'h0022;
    step();
    we = 1'b0;
    chk("locked", locked0, 1'b1);
    a0[AW-1:0] = id_addr(4'd2);
    v0 = 2'b01;
    step();
    v0 = 2'b00;
    chk("lock_route", or0[15:0], 16'h0011);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/floo_route_comp_pipe.md
Name: floo_route_comp_pipe

Overview:
Multi-channel, pipelined route-computation stage for the NoC injection path. Each channel accepts a request address or a source ID and produces:
- a destination ID, from either address-bit extraction or address-rule decode;
- a source route, looked up in a run-time programmable route table.
Results leave through a one-stage valid/ready pipeline per channel. Decode errors are flagged per beat and counted in a shared saturating error counter.

Parameters:
NumChannels, 2, number of independent request channels
AddrWidth, 48, address width
IdWidth, 4, destination ID width
RouteWidth, 16, width of one source-route entry
NumRoutes, 16, route-table depth (1..2**IdWidth)
NumRules, 8, number of address rules (>=1)
IdMode, 0, 0 = ID bits taken from address, 1 = address-rule decode, 2 = ID taken from in_id_i
IdAddrOffset, 32, LSB of the ID field in the address (IdMode 0)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
in_valid_i  in  NumChannels  per-channel request valid
in_ready_o  out  NumChannels  per-channel request ready
in_addr_i  in  NumChannels*AddrWidth  request addresses
in_id_i  in  NumChannels*IdWidth  source IDs (IdMode 2)
out_valid_o  out  NumChannels  result valid
out_ready_i  in  NumChannels  result ready
out_id_o  out  NumChannels*IdWidth  destination ID
out_route_o  out  NumChannels*RouteWidth  source route
out_err_o  out  NumChannels  decode error for this beat
rule_start_i  in  NumRules*AddrWidth  rule start address (inclusive)
rule_end_i  in  NumRules*AddrWidth  rule end address (exclusive)
rule_id_i  in  NumRules*IdWidth  rule destination ID
en_default_i  in  1  enable default ID on rule miss
default_id_i  in  IdWidth  default ID
cfg_we_i  in  1  route-table write enable
cfg_idx_i  in  $clog2(NumRoutes)  write index
cfg_wdata_i  in  RouteWidth  write data
err_clr_i  in  1  clear error counter
err_cnt_o  out  8  saturating decode-error count

Behaviour:
- Reset (rst_i high at a clock edge):
  - out_valid_o = 0; out_id_o, out_route_o and out_err_o = 0.
  - All route-table entries = 0; err_cnt_o = 0.
  - Reset mid-transfer drops any held beat.
- Per-channel pipeline:
  - in_ready_o[c] = !out_valid_o[c] || out_ready_i[c].
  - A beat is captured on in_valid && in_ready, giving 1-cycle latency.
  - An output is held stable while out_valid && !out_ready.
  - Full throughput of 1 beat/cycle per channel.
  - Channels are fully independent.
- ID computation, combinational before the register:
  - IdMode 0: id = addr[IdAddrOffset +: IdWidth]; never an error.
  - IdMode 1: rule r matches if start_r <= addr < end_r. The highest-index matching rule wins.
    - On a miss with en_default_i = 1: id = default_id_i, no error.
    - On a miss with en_default_i = 0: id = default_id_i and err = 1.
  - IdMode 2: id = in_id_i[c]; never a decode error.
- Route lookup:
  - route = table[id] when id < NumRoutes.
  - When id >= NumRoutes: route = 0 and err = 1.
- Table write:
  - cfg_we_i writes table[cfg_idx_i] at the clock edge.
  - A capture in the same cycle reads the old value (read-before-write).
  - A write with cfg_idx_i >= NumRoutes is ignored.
- Error counter:
  - Adds the number of channels capturing a beat with err = 1 in that cycle (0..NumChannels).
  - Saturates at 255; no wrap.
  - err_clr_i in the same cycle as increments: the result equals that cycle's increment (clear first, then add).
- Decode errors never stall the pipeline; the beat is forwarded with out_err_o = 1.

Optional Feature:
FLOO_ROUTE_COMP_CFG_LOCK_EN
- Defined:
  - Adds input cfg_lock_i (1 bit) and output cfg_locked_o (1 bit, reset 0).
  - cfg_lock_i = 1 at a clock edge sets cfg_locked_o; it stays set until rst_i.
  - While locked, cfg_we_i is ignored.
  - A write in the same cycle as the lock request still takes effect.
- Undefined: ports absent; the table is always writable.

Test Plan:
- Reset then idle: all outputs 0 and in_ready_o = all-ones → after 10 cycles, no out_valid_o asserted.
- IdMode 0, IdAddrOffset 32: write table[5] = 0x00A5, send addr 0x0000_0005_0000_1000 on channel 0 → next cycle out_id = 5, out_route = 0x00A5, out_err = 0.
- IdMode 1, rules {0x0-0x1000 → 1, 0x800-0x2000 → 3}:
  - addr 0x900 → id 3;
  - addr 0x3000 with en_default 0 → err 1 and err_cnt increments to 1.
- Backpressure: hold out_ready_i = 0 for 4 cycles after one capture → in_ready_o = 0, output stable. Then release → next beat accepted the same cycle.
- Both channels erroring every cycle for 130 cycles → err_cnt_o = 255 (saturated). Assert err_clr_i together with 2 errors → err_cnt_o = 2.
- With the lock macro defined: write table[2] = 0x11, lock, write table[2] = 0x22 → lookup of id 2 returns 0x11 and cfg_locked_o = 1.
